// File: rtl/bsg_manycore_req_mux_pkg.sv
// Shared constants and helpers for the manycore request concentrator.
// Exports:
//   bsg_manycore_req_mux_max_ch_gp - upper bound on request channels per tile
//   safe_clog2()                   - clog2 that never returns 0 (min 1 bit)
//   width_of()                     - bits needed to hold the value n
//   req_mux_hdr_s                  - mux output header {ch_id} at maximum width
package bsg_manycore_req_mux_pkg;

  localparam int unsigned bsg_manycore_req_mux_max_ch_gp = 8;

  function automatic int unsigned safe_clog2(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned width_of(input int unsigned n);
    return (n == 0) ? 1 : $clog2(n + 1);
  endfunction

  localparam int unsigned req_mux_ch_id_max_width_gp = safe_clog2(bsg_manycore_req_mux_max_ch_gp);

  typedef struct packed {
    logic [req_mux_ch_id_max_width_gp-1:0] ch_id;
  } req_mux_hdr_s;

endpackage

// File: rtl/bsg_manycore_req_mux_ctr.sv
// Per-channel outstanding-request counter.
// Ports:
//   clk_i, reset_n_i - clock, async active-low reset
//   inc_i            - request granted on this channel
//   dec_i            - response addressed to this channel
//   full_o           - count has reached max_out_p
//   idle_o           - count is zero
//   underflow_o      - dec_i while count is zero (count is left unchanged)
module bsg_manycore_req_mux_ctr
  import bsg_manycore_req_mux_pkg::*;
#(
  parameter int unsigned max_out_p = 16
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic inc_i,
  input  logic dec_i,
  output logic full_o,
  output logic idle_o,
  output logic underflow_o
);

  localparam int unsigned cnt_width_lp = width_of(max_out_p);

  logic [cnt_width_lp-1:0] cnt_r;
  logic                    dec_ok;

  assign idle_o      = (cnt_r == '0);
  assign full_o      = (cnt_r == cnt_width_lp'(max_out_p));
  assign underflow_o = dec_i & idle_o;
  assign dec_ok      = dec_i & ~idle_o;

  // Simultaneous inc and valid dec cancel out.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_r <= '0;
    end else begin
      case ({inc_i, dec_ok})
        2'b10:   cnt_r <= cnt_r + 1'b1;
        2'b01:   cnt_r <= cnt_r - 1'b1;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

endmodule

// File: rtl/bsg_manycore_req_mux.sv
// Merges num_ch_p request sources onto one TX port with per-channel
// outstanding limits, and routes responses back by channel id.
// Ports:
//   clk_i, reset_n_i          - clock, async active-low reset
//   req_v_i/req_data_i        - per-channel request valid and payload
//   req_yumi_o                - combinational one-hot accept
//   out_v_o/out_data_o        - registered merged request {ch_id, payload}
//   out_ready_i               - downstream accept
//   ret_v_i/ret_ch_i/ret_data_i - incoming response
//   ret_v_o/ret_data_o        - registered one-hot response pulse and data
//   ch_idle_o                 - per-channel "no outstanding requests"
//   err_o                     - sticky protocol error
module bsg_manycore_req_mux
  import bsg_manycore_req_mux_pkg::*;
#(
  parameter  int unsigned num_ch_p         = 2,
  parameter  int unsigned payload_width_p  = 64,
  parameter  int unsigned ret_data_width_p = 32,
  parameter  int unsigned max_out_p        = 16,
  parameter  int unsigned rr_mode_p        = 1,
  localparam int unsigned ch_id_width_lp   = safe_clog2(num_ch_p)
) (
  input  logic                                      clk_i,
  input  logic                                      reset_n_i,
  input  logic [num_ch_p-1:0]                       req_v_i,
  input  logic [num_ch_p*payload_width_p-1:0]       req_data_i,
  output logic [num_ch_p-1:0]                       req_yumi_o,
  output logic                                      out_v_o,
  output logic [ch_id_width_lp+payload_width_p-1:0] out_data_o,
  input  logic                                      out_ready_i,
  input  logic                                      ret_v_i,
  input  logic [ch_id_width_lp-1:0]                 ret_ch_i,
  input  logic [ret_data_width_p-1:0]               ret_data_i,
  output logic [num_ch_p-1:0]                       ret_v_o,
  output logic [ret_data_width_p-1:0]               ret_data_o,
  output logic [num_ch_p-1:0]                       ch_idle_o,
  output logic                                      err_o
);

  logic [payload_width_p-1:0] req_data [num_ch_p];
  logic [num_ch_p-1:0]        full, idle, underflow, elig, ret_hit, ret_ok;
  logic [ch_id_width_lp-1:0]  rr_ptr_r, gnt_id;
  logic                       gnt_v, grant_en, fire, ret_bad_ch;
  int unsigned                idx;

  // Per-channel counters and payload unpacking.
  for (genvar c = 0; c < num_ch_p; c++) begin : g_ch
    assign req_data[c] = req_data_i[c*payload_width_p +: payload_width_p];
    assign ret_hit[c]  = ret_v_i & (ret_ch_i == ch_id_width_lp'(c));

    bsg_manycore_req_mux_ctr #(.max_out_p(max_out_p)) u_ctr (
      .clk_i       (clk_i),
      .reset_n_i   (reset_n_i),
      .inc_i       (req_yumi_o[c]),
      .dec_i       (ret_hit[c]),
      .full_o      (full[c]),
      .idle_o      (idle[c]),
      .underflow_o (underflow[c])
    );
  end

  assign elig       = req_v_i & ~full;
  assign grant_en   = ~out_v_o | out_ready_i;
  assign fire       = grant_en & gnt_v;
  assign req_yumi_o = fire ? (num_ch_p'(1) << gnt_id) : '0;
  assign ret_ok     = ret_hit & ~idle;
  assign ret_bad_ch = ret_v_i & ~(|ret_hit);
  assign ch_idle_o  = idle;

  // Winner search: rotating start at rr_ptr_r, or fixed start at channel 0.
  always_comb begin
    gnt_v  = 1'b0;
    gnt_id = '0;
    idx    = 0;
    for (int unsigned i = 0; i < num_ch_p; i++) begin
      idx = (rr_mode_p != 0) ? 32'(rr_ptr_r) + i : i;
      if (idx >= num_ch_p) idx = idx - num_ch_p;
      if (!gnt_v && elig[ch_id_width_lp'(idx)]) begin
        gnt_v  = 1'b1;
        gnt_id = ch_id_width_lp'(idx);
      end
    end
  end

  // Output slot, rotation pointer, response path and sticky error.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      out_v_o    <= 1'b0;
      out_data_o <= '0;
      rr_ptr_r   <= '0;
      ret_v_o    <= '0;
      ret_data_o <= '0;
      err_o      <= 1'b0;
    end else begin
      if (fire) begin
        out_v_o    <= 1'b1;
        out_data_o <= {gnt_id, req_data[gnt_id]};
      end else if (out_ready_i) begin
        out_v_o    <= 1'b0;
      end
      if (fire && (rr_mode_p != 0)) begin
        rr_ptr_r <= (gnt_id == ch_id_width_lp'(num_ch_p - 1)) ? '0 : gnt_id + 1'b1;
      end
      ret_v_o <= ret_ok;
      if (|ret_ok) ret_data_o <= ret_data_i;
      err_o <= err_o | ret_bad_ch | (|underflow);
    end
  end

endmodule

// File: tb/tb_bsg_manycore_req_mux.sv
// Directed bench: a 2-channel round-robin instance (max_out 4) and a
// 4-channel fixed-priority instance (max_out 4), 16-bit payloads.
module tb_bsg_manycore_req_mux;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Instance A: num_ch 2, round-robin
  logic [1:0]  a_req_v;
  logic [31:0] a_req_data;
  logic [1:0]  a_yumi;
  logic        a_out_v;
  logic [16:0] a_out_data;
  logic        a_ready;
  logic        a_ret_v_i;
  logic [0:0]  a_ret_ch;
  logic [31:0] a_ret_data_i;
  logic [1:0]  a_ret_v_o;
  logic [31:0] a_ret_data_o;
  logic [1:0]  a_idle;
  logic        a_err;

  // Instance B: num_ch 4, fixed priority
  logic [3:0]  b_req_v;
  logic [63:0] b_req_data;
  logic [3:0]  b_yumi;
  logic        b_out_v;
  logic [17:0] b_out_data;
  logic        b_ready;
  logic        b_ret_v_i;
  logic [1:0]  b_ret_ch;
  logic [31:0] b_ret_data_i;
  logic [3:0]  b_ret_v_o;
  logic [31:0] b_ret_data_o;
  logic [3:0]  b_idle;
  logic        b_err;

  bsg_manycore_req_mux #(
    .num_ch_p(2), .payload_width_p(16), .ret_data_width_p(32),
    .max_out_p(4), .rr_mode_p(1)
  ) u_a (
    .clk_i(clk), .reset_n_i(rst_n),
    .req_v_i(a_req_v), .req_data_i(a_req_data), .req_yumi_o(a_yumi),
    .out_v_o(a_out_v), .out_data_o(a_out_data), .out_ready_i(a_ready),
    .ret_v_i(a_ret_v_i), .ret_ch_i(a_ret_ch), .ret_data_i(a_ret_data_i),
    .ret_v_o(a_ret_v_o), .ret_data_o(a_ret_data_o),
    .ch_idle_o(a_idle), .err_o(a_err)
  );

  bsg_manycore_req_mux #(
    .num_ch_p(4), .payload_width_p(16), .ret_data_width_p(32),
    .max_out_p(4), .rr_mode_p(0)
  ) u_b (
    .clk_i(clk), .reset_n_i(rst_n),
    .req_v_i(b_req_v), .req_data_i(b_req_data), .req_yumi_o(b_yumi),
    .out_v_o(b_out_v), .out_data_o(b_out_data), .out_ready_i(b_ready),
    .ret_v_i(b_ret_v_i), .ret_ch_i(b_ret_ch), .ret_data_i(b_ret_data_i),
    .ret_v_o(b_ret_v_o), .ret_data_o(b_ret_data_o),
    .ch_idle_o(b_idle), .err_o(b_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    a_req_v = '0; a_req_data = {16'h1111, 16'h1000}; a_ready = 1'b1;
    a_ret_v_i = 1'b0; a_ret_ch = '0; a_ret_data_i = '0;
    b_req_v = '0; b_req_data = {16'h3003, 16'h3002, 16'h3001, 16'h3000}; b_ready = 1'b1;
    b_ret_v_i = 1'b0; b_ret_ch = '0; b_ret_data_i = '0;

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    chk("rst_out_v", 64'(a_out_v), 64'd0);
    chk("rst_err", 64'(a_err), 64'd0);
    chk("rst_idle", 64'(a_idle), 64'h3);
    chk("rst_ret_v", 64'(a_ret_v_o), 64'd0);
    chk("rst_b_idle", 64'(b_idle), 64'hF);
    tick();
    rst_n = 1'b1;

    // Fixed priority: ch0 wins until full, then ch1
    b_req_v = 4'hF;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("fp_yumi", 64'(b_yumi), (k < 4) ? 64'h1 : 64'h2);
      tick();
      chk("fp_out_v", 64'(b_out_v), 64'd1);
      chk("fp_out_data", 64'(b_out_data), (k < 4) ? 64'h03000 : 64'h13001);
    end
    b_req_v = '0;
    tick();
    chk("fp_idle", 64'(b_idle), 64'hC);
    chk("fp_drained", 64'(b_out_v), 64'd0);
    chk("fp_no_err", 64'({b_err, b_ret_v_o, b_ret_data_o}), 64'd0);

    // Round-robin alternation with 1-cycle output latency
    a_req_v = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_yumi", 64'(a_yumi), (k % 2 == 0) ? 64'h1 : 64'h2);
      tick();
      chk("rr_out_data", 64'(a_out_data), (k % 2 == 0) ? 64'h01000 : 64'h11111);
    end
    a_req_v = '0;
    #1 chk("rr_idle_yumi", 64'(a_yumi), 64'd0);
    tick();
    chk("rr_drained", 64'(a_out_v), 64'd0);
    chk("rr_idle_busy", 64'(a_idle), 64'd0);

    // Return the four outstanding requests
    a_ret_v_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      a_ret_ch = 1'((k >= 2) ? 1 : 0);
      a_ret_data_i = 32'hA0000000 + 32'(k);
      tick();
      chk("ret_v_o", 64'(a_ret_v_o), (k >= 2) ? 64'h2 : 64'h1);
      chk("ret_data_o", 64'(a_ret_data_o), 64'hA0000000 + 64'(k));
    end
    chk("ret_idle_half", 64'(a_idle), 64'h3);
    a_ret_v_i = 1'b0;
    tick();
    chk("ret_v_o_off", 64'(a_ret_v_o), 64'd0);

    // ch0 saturates at 4, ch1 still served, a return reopens ch0
    a_req_v = 2'b01;
    for (int k = 0; k < 4; k++) begin
      #1 chk("sat_yumi", 64'(a_yumi), 64'h1);
      tick();
    end
    #1 chk("sat_full", 64'(a_yumi), 64'd0);
    a_req_v = 2'b11;
    #1 chk("sat_ch1", 64'(a_yumi), 64'h2);
    tick();
    a_req_v = 2'b01;
    a_ret_v_i = 1'b1; a_ret_ch = 1'b0; a_ret_data_i = 32'h0000CAFE;
    #1 chk("sat_still_full", 64'(a_yumi), 64'd0);
    tick();
    a_ret_v_i = 1'b0;
    chk("sat_ret_v", 64'(a_ret_v_o), 64'h1);
    #1 chk("sat_reopen", 64'(a_yumi), 64'h1);
    tick();
    chk("sat_out", 64'(a_out_data), 64'h01000);

    // Backpressure hold, then drain and grant in the same cycle
    a_ready = 1'b0;
    a_req_v = 2'b10;
    a_req_data = {16'h2222, 16'h1000};
    for (int k = 0; k < 5; k++) begin
      #1 chk("hold_yumi", 64'(a_yumi), 64'd0);
      tick();
      chk("hold_out_v", 64'(a_out_v), 64'd1);
      chk("hold_data", 64'(a_out_data), 64'h01000);
    end
    a_ready = 1'b1;
    #1 chk("drain_grant", 64'(a_yumi), 64'h2);
    tick();
    chk("drain_data", 64'(a_out_data), 64'h12222);
    a_req_v = '0;
    tick();
    chk("drain_empty", 64'(a_out_v), 64'd0);

    // ch1 holds 2; bring it to 1, then grant + return together
    a_ret_v_i = 1'b1; a_ret_ch = 1'b1; a_ret_data_i = 32'h00000011;
    tick();
    a_ret_v_i = 1'b1; a_ret_data_i = 32'hDEADBEEF;
    a_req_v = 2'b10;
    #1 chk("same_yumi", 64'(a_yumi), 64'h2);
    tick();
    a_req_v = '0; a_ret_v_i = 1'b0;
    chk("same_ret_v", 64'(a_ret_v_o), 64'h2);
    chk("same_ret_data", 64'(a_ret_data_o), 64'hDEADBEEF);
    chk("same_busy", 64'(a_idle[1]), 64'd0);
    a_ret_v_i = 1'b1; a_ret_data_i = 32'h00000022;
    tick();
    a_ret_v_i = 1'b0;
    chk("same_idle", 64'(a_idle[1]), 64'd1);

    // Drain ch0 (4 outstanding), then an extra return is an error
    a_ret_v_i = 1'b1; a_ret_ch = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("drain0_ret_v", 64'(a_ret_v_o), 64'h1);
    end
    chk("pre_err", 64'(a_err), 64'd0);
    a_ret_data_i = 32'h00000055;
    tick();
    a_ret_v_i = 1'b0;
    chk("err_set", 64'(a_err), 64'd1);
    chk("err_no_ret", 64'(a_ret_v_o), 64'd0);
    chk("err_idle", 64'(a_idle), 64'h3);
    tick();
    chk("err_sticky", 64'(a_err), 64'd1);

    // Async reset mid-transfer
    a_ready = 1'b0;
    a_req_v = 2'b11;
    tick();
    a_req_v = '0;
    chk("mid_out_v", 64'(a_out_v), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_v", 64'(a_out_v), 64'd0);
    chk("arst_err", 64'(a_err), 64'd0);
    chk("arst_idle", 64'(a_idle), 64'h3);
    tick();
    rst_n = 1'b1;
    a_ready = 1'b1;
    a_ret_v_i = 1'b1; a_ret_ch = 1'b1;
    tick();
    a_ret_v_i = 1'b0;
    chk("post_rst_err", 64'(a_err), 64'd1);
    chk("post_rst_ret_v", 64'(a_ret_v_o), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #20000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
